// File: rtl/ap_perf_pkg.sv
// Shared types and helpers for the ap_ctrl performance monitor.
package ap_perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WAIT = 2'd2
  } ch_state_t;

  localparam logic [2:0] RD_SEL_STARTS   = 3'd0;
  localparam logic [2:0] RD_SEL_DONES    = 3'd1;
  localparam logic [2:0] RD_SEL_BUSY     = 3'd2;
  localparam logic [2:0] RD_SEL_STALL    = 3'd3;
  localparam logic [2:0] RD_SEL_LAST_LAT = 3'd4;
  localparam logic [2:0] RD_SEL_MAX_LAT  = 3'd5;
  localparam logic [2:0] RD_SEL_STATUS   = 3'd6;
  localparam logic [2:0] RD_SEL_ZERO     = 3'd7;

  localparam int unsigned MAX_CNT_W = 64;

  // Increment that sticks at lim; callers zero-extend narrower counters.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                   input logic [MAX_CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 64'd1;
  endfunction

endpackage

// File: rtl/ap_perf_channel.sv
// One monitored ap_ctrl channel: handshake FSM, latency tracker and six
// saturating counters with sticky overflow flags.
module ap_perf_channel
  import ap_perf_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             start,
  input  logic             ready,
  input  logic             done,
  input  logic             cont,
  input  logic             clr,
  input  logic             freeze,
  output logic [CNT_W-1:0] starts,
  output logic [CNT_W-1:0] dones,
  output logic [CNT_W-1:0] busy_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] last_lat,
  output logic [CNT_W-1:0] max_lat,
  output logic [5:0]       ovf,
  output logic [1:0]       state_o,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(MAX_CNT_W'(v), MAX_CNT_W'(CNT_MAX)));
  endfunction

  ch_state_t        state, state_nxt;
  logic [CNT_W-1:0] lat_run;
  logic [CNT_W-1:0] lat_now;
  logic [CNT_W-1:0] ev_cnt [4];
  logic [3:0]       ev;
  logic             hs, active, lat_upd, lat_sat;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start && !done)      state_nxt = BUSY;
        else if (start && !cont) state_nxt = WAIT;
      end
      BUSY: begin
        if (done) state_nxt = !cont ? WAIT : (start ? BUSY : IDLE);
      end
      WAIT: begin
        if (cont) state_nxt = start ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hs      = done & cont;
    active  = (state != IDLE);
    ev      = {done & ~cont, active, hs, start & ready};
    // A call handshaking straight out of IDLE took exactly one cycle.
    lat_now = active ? inc_sat(lat_run) : CNT_W'(1);
    lat_sat = active && (lat_run == CNT_MAX);
    lat_upd = hs && (active || start);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      lat_run <= '0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt != IDLE);
      // Restarts from zero on every entry, including back-to-back calls.
      lat_run <= (!active || hs) ? '0 : inc_sat(lat_run);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int unsigned i = 0; i < 4; i++) ev_cnt[i] <= '0;
      last_lat <= '0;
      max_lat  <= '0;
      ovf      <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < 4; i++) ev_cnt[i] <= '0;
      last_lat <= '0;
      max_lat  <= '0;
      ovf      <= '0;
    end else if (!freeze) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (ev[i]) begin
          if (ev_cnt[i] == CNT_MAX) ovf[i] <= 1'b1;
          ev_cnt[i] <= inc_sat(ev_cnt[i]);
        end
      end
      if (lat_upd) begin
        last_lat <= lat_now;
        if (lat_now > max_lat) max_lat <= lat_now;
        if (lat_sat) begin
          ovf[4] <= 1'b1;
          ovf[5] <= 1'b1;
        end
      end
    end
  end

  assign starts    = ev_cnt[0];
  assign dones     = ev_cnt[1];
  assign busy_cnt  = ev_cnt[2];
  assign stall_cnt = ev_cnt[3];
  assign state_o   = state;

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// N-channel ap_ctrl_chain performance monitor: per-channel trackers plus a
// registered read port.
module ap_ctrl_perf_monitor
  import ap_perf_pkg::*;
#(
  parameter  int unsigned N_CH    = 4,
  parameter  int unsigned CNT_W   = 32,
  localparam int unsigned RD_CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [N_CH-1:0]    mon_start,
  input  logic [N_CH-1:0]    mon_ready,
  input  logic [N_CH-1:0]    mon_done,
  input  logic [N_CH-1:0]    mon_continue,
  input  logic               clr,
  input  logic               freeze,
  input  logic               rd_req,
  input  logic [RD_CH_W-1:0] rd_ch,
  input  logic [2:0]         rd_sel,
  output logic               rd_valid,
  output logic [CNT_W-1:0]   rd_data,
  output logic [N_CH-1:0]    ch_busy
);

  logic [CNT_W-1:0] c_starts [N_CH];
  logic [CNT_W-1:0] c_dones  [N_CH];
  logic [CNT_W-1:0] c_busy   [N_CH];
  logic [CNT_W-1:0] c_stall  [N_CH];
  logic [CNT_W-1:0] c_last   [N_CH];
  logic [CNT_W-1:0] c_max    [N_CH];
  logic [5:0]       c_ovf    [N_CH];
  logic [1:0]       c_state  [N_CH];
  logic [CNT_W-1:0] rd_mux;
  logic [CNT_W+7:0] st_ext;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ap_perf_channel #(.CNT_W(CNT_W)) u_ch (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .start     (mon_start[g]),
      .ready     (mon_ready[g]),
      .done      (mon_done[g]),
      .cont      (mon_continue[g]),
      .clr       (clr),
      .freeze    (freeze),
      .starts    (c_starts[g]),
      .dones     (c_dones[g]),
      .busy_cnt  (c_busy[g]),
      .stall_cnt (c_stall[g]),
      .last_lat  (c_last[g]),
      .max_lat   (c_max[g]),
      .ovf       (c_ovf[g]),
      .state_o   (c_state[g]),
      .busy      (ch_busy[g])
    );
  end

  // Out-of-range channels match no iteration and read as zero.
  always_comb begin
    rd_mux = '0;
    st_ext = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rd_ch == RD_CH_W'(i)) begin
        st_ext = {{CNT_W{1'b0}}, c_ovf[i], c_state[i]};
        unique case (rd_sel)
          RD_SEL_STARTS:   rd_mux = c_starts[i];
          RD_SEL_DONES:    rd_mux = c_dones[i];
          RD_SEL_BUSY:     rd_mux = c_busy[i];
          RD_SEL_STALL:    rd_mux = c_stall[i];
          RD_SEL_LAST_LAT: rd_mux = c_last[i];
          RD_SEL_MAX_LAT:  rd_mux = c_max[i];
          RD_SEL_STATUS:   rd_mux = st_ext[CNT_W-1:0];
          RD_SEL_ZERO:     rd_mux = '0;
          default:         rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Self-checking bench for ap_ctrl_perf_monitor: directed corner sequences,
// a read-back vector table and randomized calls against a call-level model.
module tb_ap_ctrl_perf_monitor;

  localparam int HOR = 600;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [3:0]  mon_start, mon_ready, mon_done, mon_continue;
  logic        clr, freeze, rd_req;
  logic [1:0]  rd_ch;
  logic [2:0]  rd_sel;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [3:0]  ch_busy;

  logic [2:0]  s_start, s_ready, s_done, s_cont;
  logic        s_clr, s_freeze, s_rd_req;
  logic [1:0]  s_rd_ch;
  logic [2:0]  s_rd_sel;
  logic        s_rd_valid;
  logic [3:0]  s_rd_data;
  logic [2:0]  s_busy;

  ap_ctrl_perf_monitor #(.N_CH(4), .CNT_W(32)) u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .mon_start(mon_start), .mon_ready(mon_ready), .mon_done(mon_done),
    .mon_continue(mon_continue), .clr(clr), .freeze(freeze),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .ch_busy(ch_busy)
  );

  ap_ctrl_perf_monitor #(.N_CH(3), .CNT_W(4)) u_sat (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .mon_start(s_start), .mon_ready(s_ready), .mon_done(s_done),
    .mon_continue(s_cont), .clr(s_clr), .freeze(s_freeze),
    .rd_req(s_rd_req), .rd_ch(s_rd_ch), .rd_sel(s_rd_sel),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data), .ch_busy(s_busy)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int          ch;
    int          sel;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;

  bit      w_st [4][HOR];
  bit      w_dn [4][HOR];
  bit      w_ct [4][HOR];
  longint  e_st [4], e_busy [4], e_stall [4], e_last [4], e_max [4];
  int      t0, h_prev, prev_len, d, s, gap, lat;
  bit      first, gen_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle();
    mon_start = '0; mon_ready = '0; mon_done = '0; mon_continue = '1;
  endtask

  task automatic s_idle();
    s_start = '0; s_ready = '0; s_done = '0; s_cont = '1;
  endtask

  task automatic setch(input int ch, input logic st, input logic rdy, input logic dn, input logic ct);
    idle();
    mon_start[ch] = st; mon_ready[ch] = rdy; mon_done[ch] = dn; mon_continue[ch] = ct;
  endtask

  // One call: start/ready at k=0, done from k=dd, continue withheld for ss cycles.
  task automatic run_call(input int ch, input int dd, input int ss);
    for (int k = 0; k <= dd + ss; k++) begin
      setch(ch, k == 0, k == 0, k >= dd, !(k >= dd && k < dd + ss));
      tick();
    end
    idle();
  endtask

  task automatic chk_rd(input string name, input int ch, input int sel, input logic [63:0] exp);
    rd_ch = ch[1:0]; rd_sel = sel[2:0]; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk({name, "_valid"}, 64'(rd_valid), 64'd1);
    chk(name, 64'(rd_data), exp);
  endtask

  task automatic chk_srd(input string name, input int ch, input int sel, input logic [63:0] exp);
    s_rd_ch = ch[1:0]; s_rd_sel = sel[2:0]; s_rd_req = 1'b1;
    tick();
    s_rd_req = 1'b0;
    chk({name, "_valid"}, 64'(s_rd_valid), 64'd1);
    chk(name, 64'(s_rd_data), exp);
  endtask

  task automatic add(input int ch, input int sel, input logic [31:0] exp);
    vec_t v;
    v.ch = ch; v.sel = sel; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic pulse_reset();
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle(); s_idle();
    clr = 0; freeze = 0; rd_req = 0; rd_ch = '0; rd_sel = '0;
    s_clr = 0; s_freeze = 0; s_rd_req = 0; s_rd_ch = '0; s_rd_sel = '0;
    rd_req = 1'b1;
    tick(); tick();
    chk("rst_rd_valid", 64'(rd_valid), 0);
    chk("rst_rd_data", 64'(rd_data), 0);
    chk("rst_ch_busy", 64'(ch_busy), 0);
    chk("rst_sat_busy", 64'(s_busy), 0);
    rd_req = 1'b0;
    ap_rst_n = 1'b1;
    tick();
    chk_rd("rst_starts0", 0, 0, 0);

    // Start held, ready+done at cycle 10: back-to-back restart, then frozen.
    for (int k = 0; k <= 10; k++) begin
      setch(0, 1'b1, k == 10, k == 10, 1'b1);
      tick();
      if (k == 0) chk("t1_busy_enter", 64'(ch_busy[0]), 1);
    end
    idle();
    freeze = 1'b1;
    tick();
    chk("t1_busy_b2b", 64'(ch_busy[0]), 1);
    setch(0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    idle();
    chk("t1_busy_frozen_end", 64'(ch_busy[0]), 0);
    freeze = 1'b0;

    // Done held 3 cycles without continue; status read mid-stall.
    rd_ch = 2'd1; rd_sel = 3'd6;
    for (int k = 0; k <= 7; k++) begin
      setch(1, k == 0, k == 0, k >= 4, !(k >= 4 && k < 7));
      rd_req = (k == 5);
      tick();
      if (k == 5) chk("t2_state_wait", 64'(rd_data), 2);
    end
    rd_req = 1'b0;
    idle();
    chk("t2_idle_after", 64'(ch_busy[1]), 0);

    // Latencies 5, 12, 7.
    run_call(2, 5, 0);  tick();
    run_call(2, 12, 0); tick();
    run_call(2, 7, 0);  tick();

    add(0, 0, 1); add(0, 1, 1); add(0, 2, 10); add(0, 3, 0); add(0, 4, 10); add(0, 5, 10);
    add(1, 0, 1); add(1, 1, 1); add(1, 2, 7);  add(1, 3, 3); add(1, 4, 7);  add(1, 5, 7);
    add(1, 6, 0);
    add(2, 0, 3); add(2, 1, 3); add(2, 2, 24); add(2, 3, 0); add(2, 4, 7);  add(2, 5, 12);
    add(2, 7, 0); add(3, 2, 0); add(3, 6, 0);
    for (int i = 0; i < tbl.size(); i++)
      chk_rd($sformatf("tbl%0d_ch%0d_sel%0d", i, tbl[i].ch, tbl[i].sel),
             tbl[i].ch, tbl[i].sel, 64'(tbl[i].exp));

    // Freeze over a whole call, then a latency-6 call with a same-cycle read.
    freeze = 1'b1;
    run_call(3, 4, 1);
    freeze = 1'b0;
    tick();
    chk_rd("t5_starts", 3, 0, 0);
    chk_rd("t5_busy", 3, 2, 0);
    chk_rd("t5_stall", 3, 3, 0);
    chk_rd("t5_last", 3, 4, 0);
    setch(3, 1'b1, 1'b1, 1'b0, 1'b1);
    rd_ch = 2'd3; rd_sel = 3'd0; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("t5_read_old", 64'(rd_data), 0);
    for (int k = 1; k <= 6; k++) begin
      setch(3, 1'b0, 1'b0, k == 6, 1'b1);
      tick();
    end
    idle();
    chk_rd("t5_last6", 3, 4, 6);
    chk_rd("t5_starts1", 3, 0, 1);
    chk_rd("t5_busy6", 3, 2, 6);

    // Saturation on the 4-bit instance.
    for (int i = 0; i < 20; i++) begin
      s_start[0] = 1; s_ready[0] = 1; s_done[0] = 1; s_cont[0] = 1;
      tick();
    end
    s_idle();
    chk_srd("t4_starts", 0, 0, 15);
    chk_srd("t4_dones", 0, 1, 15);
    chk_srd("t4_status", 0, 6, 12);
    chk_srd("t4_last", 0, 4, 1);
    chk_srd("t4_busy", 0, 2, 0);
    chk_srd("t4_bad_ch", 3, 0, 0);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    chk_srd("t4_clr_starts", 0, 0, 0);
    chk_srd("t4_clr_status", 0, 6, 0);
    s_clr = 1'b1;
    s_start[1] = 1; s_ready[1] = 1; s_done[1] = 1; s_cont[1] = 1;
    tick();
    s_clr = 1'b0;
    s_idle();
    chk_srd("t6_clr_win_starts", 1, 0, 0);
    chk_srd("t6_clr_win_last", 1, 4, 0);
    s_start[1] = 1; s_ready[1] = 1; s_done[1] = 1; s_cont[1] = 1;
    tick();
    s_idle();
    chk_srd("t6_after_clr", 1, 0, 1);

    // Reset mid-BUSY.
    setch(0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    chk("t6_busy_pre", 64'(ch_busy[0]), 1);
    chk_rd("t6_pre_starts2", 2, 0, 3);
    ap_rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(ch_busy), 0);
    chk("t6_rst_data", 64'(rd_data), 0);
    rd_req = 1'b1; rd_ch = 2'd2; rd_sel = 3'd0;
    tick();
    chk("t6_rst_rd_ignored", 64'(rd_valid), 0);
    rd_req = 1'b0;
    ap_rst_n = 1'b1;
    setch(1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    chk_rd("t6_post_starts2", 2, 0, 0);
    chk_rd("t6_post_status0", 0, 6, 0);
    chk_rd("t6_first_cycle", 1, 0, 1);

    // Randomized calls per channel, checked against call-level arithmetic.
    pulse_reset();
    for (int ch = 0; ch < 4; ch++) begin
      for (int c = 0; c < HOR; c++) begin
        w_st[ch][c] = 0; w_dn[ch][c] = 0; w_ct[ch][c] = 1;
      end
      e_st[ch] = 0; e_busy[ch] = 0; e_stall[ch] = 0; e_last[ch] = 0; e_max[ch] = 0;
      first = 1; h_prev = 0; prev_len = 0; gen_done = 0;
      while (!gen_done) begin
        d   = int'($urandom_range(10, 0));
        s   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(4, 1)) : 0;
        gap = int'($urandom_range(4, 0));
        t0  = first ? int'($urandom_range(3, 0)) : h_prev + gap;
        if (!first && gap == 0) begin
          if (prev_len == 0) t0 = h_prev + 1;
          else if (d == 0) d = 1;
        end
        if (t0 + d + s >= HOR - 4) gen_done = 1;
        else begin
          w_st[ch][t0] = 1;
          for (int k = 0; k <= d + s; k++) begin
            if (k >= d) w_dn[ch][t0 + k] = 1;
            if (k >= d && k < d + s) w_ct[ch][t0 + k] = 0;
          end
          lat = (d + s == 0) ? 1 : d + s;
          e_st[ch]++;
          e_busy[ch]  += d + s;
          e_stall[ch] += s;
          e_last[ch]  = lat;
          if (lat > e_max[ch]) e_max[ch] = lat;
          h_prev = t0 + d + s; prev_len = d + s; first = 0;
        end
      end
    end
    for (int c = 0; c < HOR; c++) begin
      for (int ch = 0; ch < 4; ch++) begin
        mon_start[ch] = w_st[ch][c]; mon_ready[ch] = w_st[ch][c];
        mon_done[ch] = w_dn[ch][c];  mon_continue[ch] = w_ct[ch][c];
      end
      tick();
    end
    idle();
    chk("rnd_all_idle", 64'(ch_busy), 0);
    for (int ch = 0; ch < 4; ch++) begin
      chk_rd($sformatf("rnd_starts_ch%0d", ch), ch, 0, 64'(e_st[ch]));
      chk_rd($sformatf("rnd_dones_ch%0d", ch), ch, 1, 64'(e_st[ch]));
      chk_rd($sformatf("rnd_busy_ch%0d", ch), ch, 2, 64'(e_busy[ch]));
      chk_rd($sformatf("rnd_stall_ch%0d", ch), ch, 3, 64'(e_stall[ch]));
      chk_rd($sformatf("rnd_last_ch%0d", ch), ch, 4, 64'(e_last[ch]));
      chk_rd($sformatf("rnd_max_ch%0d", ch), ch, 5, 64'(e_max[ch]));
      chk_rd($sformatf("rnd_status_ch%0d", ch), ch, 6, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
